// File: rtl/ysyx_22041412_mul_ctrl_if.sv
// Request/response and multiplier-side bundle for the multiply controller.
// slave = controller view, master = pipeline/multiplier environment view.
interface ysyx_22041412_mul_ctrl_if #(
   parameter int XLEN = 64
);
   logic            flush_i;
   logic            req_valid_i;
   logic            req_ready_o;
   logic [1:0]      op_i;
   logic            word_i;
   logic [XLEN-1:0] src1_i;
   logic [XLEN-1:0] src2_i;
   logic            resp_valid_o;
   logic            resp_ready_i;
   logic [XLEN-1:0] resp_data_o;
   logic            mul_req_o;
   logic [XLEN-1:0] mul_a_o;
   logic [XLEN-1:0] mul_b_o;
   logic            mul_w_o;
   logic [1:0]      mul_signed_o;
   logic            mul_mode_o;
   logic            mul_valid_i;
   logic [XLEN-1:0] mul_result_i;
   logic            mul_ready_o;

   modport slave (
      input  flush_i, req_valid_i, op_i, word_i, src1_i, src2_i, resp_ready_i,
             mul_valid_i, mul_result_i,
      output req_ready_o, resp_valid_o, resp_data_o, mul_req_o, mul_a_o, mul_b_o,
             mul_w_o, mul_signed_o, mul_mode_o, mul_ready_o
   );

   modport master (
      output flush_i, req_valid_i, op_i, word_i, src1_i, src2_i, resp_ready_i,
             mul_valid_i, mul_result_i,
      input  req_ready_o, resp_valid_o, resp_data_o, mul_req_o, mul_a_o, mul_b_o,
             mul_w_o, mul_signed_o, mul_mode_o, mul_ready_o
   );
endinterface

// File: rtl/ysyx_22041412_mul_ctrl.sv
// Sequences RV64M multiplies onto the iterative Booth multiplier; accept->resp_valid is 1 cycle
// on a zero operand, else multiplier latency + 1. Result is held in RESP until resp_ready_i.
module ysyx_22041412_mul_ctrl #(
   parameter int XLEN      = 64,
   parameter int DRAIN_CYC = 2
) (
   input logic                      clk,
   input logic                      rst,
   ysyx_22041412_mul_ctrl_if.slave  bus
);
   localparam int CW = $clog2(DRAIN_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_DRAIN} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
   logic            w_q, w_d, mode_q, mode_d, vld_q, vld_d;
   logic [1:0]      sgn_q, sgn_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            req_ready, mul_req, mul_ready, is_w;

   assign is_w = bus.word_i && (bus.op_i == 2'b00);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      w_d       = w_q;
      sgn_d     = sgn_q;
      mode_d    = mode_q;
      data_d    = data_q;
      vld_d     = vld_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      mul_req   = 1'b0;
      mul_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (bus.req_valid_i && !bus.flush_i) begin
               a_d = bus.src1_i;
               b_d = bus.src2_i;
               w_d = is_w;
               case (bus.op_i)
                  2'b00:   begin sgn_d = is_w ? 2'b00 : 2'b11; mode_d = 1'b0; end
                  2'b01:   begin sgn_d = 2'b11; mode_d = 1'b1; end
                  2'b10:   begin sgn_d = 2'b10; mode_d = 1'b1; end
                  default: begin sgn_d = 2'b00; mode_d = 1'b1; end
               endcase
               // A zero operand makes every product form zero; skip the multiplier entirely.
               if (bus.src1_i == '0 || bus.src2_i == '0) begin
                  data_d  = '0;
                  vld_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (bus.flush_i) begin
               mul_ready = 1'b1;
               cnt_d     = CW'(DRAIN_CYC - 1);
               state_d   = S_DRAIN;
            end else if (bus.mul_valid_i) begin
               mul_ready = 1'b1;
               data_d    = w_q ? {{(XLEN-32){bus.mul_result_i[31]}}, bus.mul_result_i[31:0]}
                               : bus.mul_result_i;
               vld_d     = 1'b1;
               state_d   = S_RESP;
            end else begin
               mul_req = 1'b1;
            end
         end
         S_RESP: begin
            if (bus.flush_i || bus.resp_ready_i) begin
               vld_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            // Hold the release high so any late multiplier valid is cleared.
            mul_ready = 1'b1;
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         w_q     <= 1'b0;
         sgn_q   <= 2'b00;
         mode_q  <= 1'b0;
         data_q  <= '0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         w_q     <= w_d;
         sgn_q   <= sgn_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.req_ready_o  = req_ready;
   assign bus.mul_req_o    = mul_req;
   assign bus.mul_ready_o  = mul_ready;
   assign bus.resp_valid_o = vld_q;
   assign bus.resp_data_o  = data_q;
   assign bus.mul_a_o      = a_q;
   assign bus.mul_b_o      = b_q;
   assign bus.mul_w_o      = w_q;
   assign bus.mul_signed_o = sgn_q;
   assign bus.mul_mode_o   = mode_q;
endmodule

// File: tb/tb_ysyx_22041412_mul_ctrl.sv
// Directed and random bench for the multiply controller, with a behavioural multiplier and RV64M reference.
module tb_ysyx_22041412_mul_ctrl;
   localparam int XLEN = 64;

   logic clk;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   ysyx_22041412_mul_ctrl_if #(.XLEN(XLEN)) bus ();

   ysyx_22041412_mul_ctrl #(.XLEN(XLEN), .DRAIN_CYC(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RV64M architectural result, straight from the instruction definitions.
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic word,
                                              input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sa, sb, ub;
      logic [127:0]        ua, ubu, p;
      logic [63:0]         lo;
      sa  = $signed(a);
      sb  = $signed(b);
      ub  = {64'd0, b};
      ua  = {64'd0, a};
      ubu = {64'd0, b};
      case (op)
         2'b00: begin
            lo = a * b;
            return word ? {{32{lo[31]}}, lo[31:0]} : lo;
         end
         2'b01:   begin p = sa * sb; return p[127:64]; end
         2'b10:   begin p = sa * ub; return p[127:64]; end
         default: begin p = ua * ubu; return p[127:64]; end
      endcase
   endfunction

   // Multiplier behaviour driven by the control encoding it is handed (32-bit mode leaves upper bits raw).
   function automatic logic [63:0] mul_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] sgn, input logic mode);
      logic signed [129:0] pa, pb, pr;
      pa = sgn[1] ? {{66{a[63]}}, a} : {66'd0, a};
      pb = sgn[0] ? {{66{b[63]}}, b} : {66'd0, b};
      pr = pa * pb;
      return mode ? pr[127:64] : pr[63:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
      int n = 0;
      while (!bus.req_ready_o && n < 20) begin tick(); n++; end
      check("req_ready_before_issue", bus.req_ready_o, 1);
      bus.req_valid_i = 1'b1;
      bus.op_i        = op;
      bus.word_i      = word;
      bus.src1_i      = a;
      bus.src2_i      = b;
      tick();
      bus.req_valid_i = 1'b0;
      bus.src1_i      = 64'($urandom);
      #1;
   endtask

   task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input int lat, input int stall);
      logic [63:0] exp;
      logic [1:0]  e_sgn;
      logic        e_mode, e_w;
      exp    = ref_result(op, word, a, b);
      e_w    = word && (op == 2'b00);
      e_mode = (op != 2'b00);
      e_sgn  = (op == 2'b01) ? 2'b11 : (op == 2'b10) ? 2'b10 : (op == 2'b11) ? 2'b00 : (e_w ? 2'b00 : 2'b11);
      issue(op, word, a, b);
      if (a == 64'd0 || b == 64'd0) begin
         check("zero_resp_valid", bus.resp_valid_o, 1);
         check("zero_no_mul_req", bus.mul_req_o, 0);
      end else begin
         check("issue_mul_req", bus.mul_req_o, 1);
         check("issue_req_ready", bus.req_ready_o, 0);
         check("issue_signed", bus.mul_signed_o, e_sgn);
         check("issue_mode", bus.mul_mode_o, e_mode);
         check("issue_w", bus.mul_w_o, e_w);
         check("issue_a", bus.mul_a_o, a);
         check("issue_b", bus.mul_b_o, b);
         for (int i = 1; i < lat; i++) begin
            tick();
            check("hold_mul_req", bus.mul_req_o, 1);
            check("hold_mul_ready", bus.mul_ready_o, 0);
            check("hold_resp_valid", bus.resp_valid_o, 0);
         end
         bus.mul_valid_i  = 1'b1;
         bus.mul_result_i = mul_model(bus.mul_a_o, bus.mul_b_o, bus.mul_signed_o, bus.mul_mode_o);
         #1;
         check("done_mul_req_drop", bus.mul_req_o, 0);
         check("done_mul_ready_pulse", bus.mul_ready_o, 1);
         tick();
         bus.mul_valid_i  = 1'b0;
         bus.mul_result_i = {$urandom, $urandom};
         #1;
         check("resp_mul_ready_low", bus.mul_ready_o, 0);
         check("resp_valid", bus.resp_valid_o, 1);
      end
      check("resp_data", bus.resp_data_o, exp);
      for (int i = 0; i < stall; i++) begin
         tick();
         check("stall_valid", bus.resp_valid_o, 1);
         check("stall_data", bus.resp_data_o, exp);
         check("stall_req_ready", bus.req_ready_o, 0);
      end
      bus.resp_ready_i = 1'b1;
      tick();
      bus.resp_ready_i = 1'b0;
      #1;
      check("post_hs_valid", bus.resp_valid_o, 0);
      check("post_hs_req_ready", bus.req_ready_o, 1);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic        r_w;
      logic [63:0] r_a, r_b;
      rst              = 1'b0;
      bus.flush_i      = 1'b0;
      bus.req_valid_i  = 1'b0;
      bus.op_i         = 2'b00;
      bus.word_i       = 1'b0;
      bus.src1_i       = '0;
      bus.src2_i       = '0;
      bus.resp_ready_i = 1'b0;
      bus.mul_valid_i  = 1'b0;
      bus.mul_result_i = '0;
      tick();
      tick();
      check("rst_req_ready", bus.req_ready_o, 1);
      check("rst_resp_valid", bus.resp_valid_o, 0);
      check("rst_resp_data", bus.resp_data_o, 0);
      check("rst_mul_req", bus.mul_req_o, 0);
      check("rst_mul_ready", bus.mul_ready_o, 0);
      check("rst_mul_a", bus.mul_a_o, 0);
      check("rst_mul_signed", bus.mul_signed_o, 0);
      rst = 1'b1;
      tick();

      run_op(2'b00, 1'b0, 64'd3, 64'd5, 4, 0);
      run_op(2'b01, 1'b0, '1, '1, 3, 0);
      run_op(2'b11, 1'b0, '1, '1, 2, 0);
      run_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd7, 1, 0);
      run_op(2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 3, 0);
      run_op(2'b11, 1'b0, 64'd0, 64'h1234, 1, 0);
      run_op(2'b01, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 2, 4);

      // Flush after five ISSUE cycles, late valid during drain.
      issue(2'b00, 1'b0, 64'd11, 64'd13);
      for (int i = 0; i < 4; i++) tick();
      check("pre_flush_mul_req", bus.mul_req_o, 1);
      bus.flush_i = 1'b1;
      #1;
      check("flush_mul_req", bus.mul_req_o, 0);
      check("flush_mul_ready", bus.mul_ready_o, 1);
      tick();
      bus.flush_i     = 1'b0;
      bus.mul_valid_i = 1'b1;
      #1;
      check("drain1_mul_ready", bus.mul_ready_o, 1);
      check("drain1_mul_req", bus.mul_req_o, 0);
      check("drain1_req_ready", bus.req_ready_o, 0);
      tick();
      check("drain2_mul_ready", bus.mul_ready_o, 1);
      check("drain2_req_ready", bus.req_ready_o, 0);
      tick();
      bus.mul_valid_i = 1'b0;
      #1;
      check("after_drain_req_ready", bus.req_ready_o, 1);
      check("after_drain_resp_valid", bus.resp_valid_o, 0);
      tick();
      check("after_drain_no_resp", bus.resp_valid_o, 0);

      // Flush coinciding with multiplier valid: flush wins.
      issue(2'b01, 1'b0, 64'd7, 64'd9);
      tick();
      bus.flush_i      = 1'b1;
      bus.mul_valid_i  = 1'b1;
      bus.mul_result_i = 64'hDEAD;
      #1;
      check("flushv_mul_ready", bus.mul_ready_o, 1);
      check("flushv_mul_req", bus.mul_req_o, 0);
      tick();
      bus.flush_i     = 1'b0;
      bus.mul_valid_i = 1'b0;
      #1;
      check("flushv_no_resp", bus.resp_valid_o, 0);
      check("flushv_draining", bus.req_ready_o, 0);
      tick();
      tick();
      check("flushv_idle", bus.req_ready_o, 1);

      // Flush in RESP discards the result.
      issue(2'b11, 1'b0, 64'h55, 64'd0);
      check("fresp_valid", bus.resp_valid_o, 1);
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      #1;
      check("fresp_dropped", bus.resp_valid_o, 0);
      check("fresp_idle", bus.req_ready_o, 1);

      // Flush in IDLE blocks acceptance.
      bus.req_valid_i = 1'b1;
      bus.flush_i     = 1'b1;
      bus.src1_i      = 64'd0;
      bus.src2_i      = 64'd0;
      tick();
      bus.req_valid_i = 1'b0;
      bus.flush_i     = 1'b0;
      #1;
      check("fidle_no_resp", bus.resp_valid_o, 0);
      check("fidle_still_idle", bus.req_ready_o, 1);

      // Reset mid-ISSUE.
      issue(2'b00, 1'b0, 64'd21, 64'd4);
      tick();
      rst = 1'b0;
      tick();
      check("rstiss_mul_req", bus.mul_req_o, 0);
      check("rstiss_resp_valid", bus.resp_valid_o, 0);
      check("rstiss_req_ready", bus.req_ready_o, 1);
      check("rstiss_mul_a", bus.mul_a_o, 0);
      rst = 1'b1;
      tick();

      for (int k = 0; k < 40; k++) begin
         r_op = 2'($urandom_range(0, 3));
         r_w  = (r_op == 2'b00) ? 1'($urandom_range(0, 1)) : 1'b0;
         r_a  = {$urandom, $urandom};
         r_b  = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) r_a = '0;
         if ($urandom_range(0, 7) == 0) r_b = '0;
         run_op(r_op, r_w, r_a, r_b, $urandom_range(1, 6), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
